imem_arbiter: RTL

//  Shares one synchronous single-port instruction memory (1-cycle read latency) between
//  two requesters: the core fetch unit (read-only) and the program loader (read/write,

---
 rtl/imem_arb_pkg.sv | 22 ++
 rtl/imem_arb_starve_cnt.sv | 33 +++
 rtl/imem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
// Optional feature macro: IMEM_ARB_PERF_EN (performance counters in imem_arbiter).
package imem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    // Who owns the response slot one cycle after a grant
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    // A byte address is bad when not word aligned or beyond the memory depth
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr, input int unsigned depth_log2);
        logic [ADDR_W-1:0] w_hi;
        w_hi = addr >> (depth_log2 + 2);
        return (addr[1:0] != 2'b00) || (w_hi != '0);
    endfunction

endpackage

// File: rtl/imem_arb_starve_cnt.sv
// Saturating count of loader grants taken while fetch is waiting.
// force_fetch hands the next grant to fetch once the limit is reached.
module imem_arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fetch_req,
    input  logic fetch_gnt,
    input  logic ld_gnt,
    output logic force_fetch
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_max;

    assign w_at_max    = (r_cnt == CW'(STARVE_MAX));
    assign force_fetch = w_at_max;

    // Count loader wins against a pending fetch; clear when fetch is served or idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!fetch_req || fetch_gnt) begin
            r_cnt <= '0;
        end else if (ld_gnt && !w_at_max) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Two-requester arbiter in front of a 1-cycle-latency single-port I-mem.
// Loader has priority, fetch is guaranteed a slot after STARVE_MAX loader wins.
// Optional: define IMEM_ARB_PERF_EN to add grant/stall performance counters.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_W-1:0]     fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [DATA_W-1:0]     fetch_rdata,
    output logic                  fetch_err,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [DATA_W-1:0]     ld_wdata,
    output logic                  ld_gnt,
    output logic                  ld_rvalid,
    output logic [DATA_W-1:0]     ld_rdata,
    output logic                  ld_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_ld_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    logic   w_force_fetch;
    logic   w_fetch_gnt;
    logic   w_ld_gnt;
    logic   w_any_gnt;
    logic   w_err;
    logic   w_mem_en;
    logic   w_rdata_ok;
    owner_e r_own;
    logic   r_err;
    logic   r_rd;

    imem_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_gnt   (w_fetch_gnt),
        .ld_gnt      (w_ld_gnt),
        .force_fetch (w_force_fetch)
    );

    assign w_fetch_gnt = fetch_req && (!ld_req || w_force_fetch);
    assign w_ld_gnt    = ld_req && !w_fetch_gnt;
    assign w_any_gnt   = w_fetch_gnt || w_ld_gnt;
    assign w_err       = w_fetch_gnt ? addr_bad(fetch_addr, DEPTH_LOG2)
                                     : addr_bad(ld_addr, DEPTH_LOG2);
    assign w_mem_en    = w_any_gnt && !w_err;

    assign fetch_gnt = w_fetch_gnt;
    assign ld_gnt    = w_ld_gnt;
    assign mem_en    = w_mem_en;
    assign mem_we    = w_mem_en && w_ld_gnt && ld_we;
    // Idle/errored cycles drive zeros so the memory bus stays quiet
    assign mem_addr  = !w_mem_en   ? '0
                     : w_fetch_gnt ? fetch_addr[DEPTH_LOG2+1:2]
                                   : ld_addr[DEPTH_LOG2+1:2];
    assign mem_wdata = mem_we ? ld_wdata : '0;

    // Remember who was granted, whether it errored and whether it was a read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_own <= OWN_NONE;
            r_err <= 1'b0;
            r_rd  <= 1'b0;
        end else begin
            r_own <= w_fetch_gnt ? OWN_FETCH : (w_ld_gnt ? OWN_LOAD : OWN_NONE);
            r_err <= w_any_gnt && w_err;
            r_rd  <= !(w_ld_gnt && ld_we);
        end
    end

    assign w_rdata_ok   = !r_err && r_rd;
    assign fetch_rvalid = (r_own == OWN_FETCH);
    assign fetch_err    = fetch_rvalid && r_err;
    assign fetch_rdata  = (fetch_rvalid && w_rdata_ok) ? mem_rdata : '0;
    assign ld_rvalid    = (r_own == OWN_LOAD);
    assign ld_err       = ld_rvalid && r_err;
    assign ld_rdata     = (ld_rvalid && w_rdata_ok) ? mem_rdata : '0;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_ld;
    logic [31:0] r_perf_stall;

    // Free-running grant and fetch-stall counters, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= '0;
            r_perf_ld    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_fetch_gnt)              r_perf_fetch <= r_perf_fetch + 32'd1;
            if (w_ld_gnt)                 r_perf_ld    <= r_perf_ld + 32'd1;
            if (fetch_req && !w_fetch_gnt) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_ld_cnt    = r_perf_ld;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
